duel_referee: RTL and testbench

//  Turn sequencer and judge sitting directly upstream of the two Player instances.

---
 rtl/duel_referee_if.sv | 34 +++
 rtl/duel_referee.sv | 158 +++++++++++++++
 tb/tb_duel_referee.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/duel_referee_if.sv
// Handshake and Player-bus bundle between the duel referee and its environment.
// slave  : the referee side (takes actions and health, drives Player controls/status).
// master : the environment side (action sources, Players, status consumers).
interface duel_referee_if;
   logic       start;
   logic [2:0] p1_in_act;
   logic       p1_in_vld;
   logic       p1_in_rdy;
   logic [2:0] p2_in_act;
   logic       p2_in_vld;
   logic       p2_in_rdy;
   logic [1:0] p1_hlt;
   logic [1:0] p2_hlt;
   logic [2:0] p1_act;
   logic [2:0] p2_act;
   logic       ply_en_n;
   logic       ply_sw;
   logic       ply_rst;
   logic [7:0] turn_cnt;
   logic       game_over;
   logic [1:0] winner;

   modport slave (
      input  start, p1_in_act, p1_in_vld, p2_in_act, p2_in_vld, p1_hlt, p2_hlt,
      output p1_in_rdy, p2_in_rdy, p1_act, p2_act, ply_en_n, ply_sw, ply_rst,
             turn_cnt, game_over, winner
   );

   modport master (
      output start, p1_in_act, p1_in_vld, p2_in_act, p2_in_vld, p1_hlt, p2_hlt,
      input  p1_in_rdy, p2_in_rdy, p1_act, p2_act, ply_en_n, ply_sw, ply_rst,
             turn_cnt, game_over, winner
   );
endinterface

// File: rtl/duel_referee.sv
// duel_referee: turn sequencer and judge for two Players.
// Collects one action per player, issues a single Player step, then judges
// health / turn limit. Every output is a register decoded from the next state.
// Optional feature macro: DUEL_TIMEOUT_EN -- missing actions become none after
// TIMEOUT_CYC collect cycles; without it, collection waits indefinitely.
module duel_referee #(
   parameter int MAX_TURNS   = 30,
   parameter int TIMEOUT_CYC = 1000
) (
   input logic           clk,
   input logic           rst,
   duel_referee_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, INIT, COLLECT, STEP, SETTLE, CHECK, OVER
   } state_t;

   localparam logic [7:0] MAX_T = 8'(MAX_TURNS);

   // Bad parameter values stop elaboration rather than giving a silently odd referee.
   if (MAX_TURNS < 1 || MAX_TURNS > 255 || TIMEOUT_CYC < 1) begin : g_cfg_err
      $error("duel_referee: MAX_TURNS must be 1..255 and TIMEOUT_CYC >= 1");
   end

   state_t          state, state_nxt;
   // slot index 0 is player 1, index 1 is player 2
   logic [1:0][2:0] in_act;
   logic [1:0]      in_vld;
   logic [1:0][2:0] act_q, act_nxt;
   logic [1:0]      full_q, full_nxt;
   logic [1:0]      rdy_q, rdy_nxt;
   logic [7:0]      turn_q, turn_nxt, turn_inc;
   logic            over_q, over_nxt;
   logic [1:0]      win_q, win_nxt;
   logic            prst_q, en_n_q, sw_q;
   logic [1:0]      h1, h2;

   assign in_act = {bus.p2_in_act, bus.p1_in_act};
   assign in_vld = {bus.p2_in_vld, bus.p1_in_vld};
   assign h1     = bus.p1_hlt;
   assign h2     = bus.p2_hlt;

`ifdef DUEL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q;
   logic          tmo_hit;

   // Collect-cycle counter: zero outside COLLECT so every entry starts fresh.
   always_ff @(posedge clk) begin
      if (rst || state != COLLECT) tmo_q <= '0;
      else                         tmo_q <= tmo_q + 1'b1;
   end

   // Fires in the last allowed collect cycle; the edge ending it fills empty slots.
   assign tmo_hit = (state == COLLECT) && (tmo_q == TW'(TIMEOUT_CYC - 1));
`endif

   // Next state plus next values of every registered output.
   always_comb begin
      state_nxt = state;
      act_nxt   = act_q;
      full_nxt  = full_q;
      turn_nxt  = turn_q;
      over_nxt  = over_q;
      win_nxt   = win_q;
      rdy_nxt   = '0;
      turn_inc  = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
      case (state)
         IDLE, OVER: if (bus.start) state_nxt = INIT;
         INIT: begin
            act_nxt   = '0;
            full_nxt  = '0;
            turn_nxt  = '0;
            over_nxt  = 1'b0;
            win_nxt   = 2'b00;
            state_nxt = COLLECT;
         end
         COLLECT: begin
            for (int i = 0; i < 2; i++) begin
               if (in_vld[i] && rdy_q[i]) begin
                  // 3'b111 is not a legal action and is treated as none
                  act_nxt[i]  = (in_act[i] == 3'b111) ? 3'd0 : in_act[i];
                  full_nxt[i] = 1'b1;
               end
            end
`ifdef DUEL_TIMEOUT_EN
            if (tmo_hit) begin
               for (int i = 0; i < 2; i++) begin
                  if (!full_nxt[i]) act_nxt[i] = 3'd0;
               end
               full_nxt = 2'b11;
            end
`endif
            if (&full_nxt) state_nxt = STEP;
         end
         STEP:   state_nxt = SETTLE;
         SETTLE: state_nxt = CHECK;
         CHECK: begin
            if (h1 == 2'd0 || h2 == 2'd0) begin
               win_nxt   = {h1 == 2'd0, h2 == 2'd0};
               over_nxt  = 1'b1;
               state_nxt = OVER;
            end else begin
               turn_nxt = turn_inc;
               if (turn_inc == MAX_T) begin
                  win_nxt   = (h1 > h2) ? 2'b01 : (h2 > h1) ? 2'b10 : 2'b11;
                  over_nxt  = 1'b1;
                  state_nxt = OVER;
               end else begin
                  act_nxt   = '0;
                  full_nxt  = '0;
                  state_nxt = COLLECT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      for (int i = 0; i < 2; i++) rdy_nxt[i] = (state_nxt == COLLECT) && !full_nxt[i];
   end

   // State and output registers; synchronous reset kills any turn in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         act_q  <= '0;
         full_q <= '0;
         rdy_q  <= '0;
         turn_q <= '0;
         over_q <= 1'b0;
         win_q  <= 2'b00;
         prst_q <= 1'b0;
         en_n_q <= 1'b1;
         sw_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         act_q  <= act_nxt;
         full_q <= full_nxt;
         rdy_q  <= rdy_nxt;
         turn_q <= turn_nxt;
         over_q <= over_nxt;
         win_q  <= win_nxt;
         prst_q <= (state_nxt == INIT);
         en_n_q <= (state_nxt != STEP);
         sw_q   <= (state_nxt == STEP);
      end
   end

   assign bus.p1_in_rdy = rdy_q[0];
   assign bus.p2_in_rdy = rdy_q[1];
   assign bus.p1_act    = act_q[0];
   assign bus.p2_act    = act_q[1];
   assign bus.ply_en_n  = en_n_q;
   assign bus.ply_sw    = sw_q;
   assign bus.ply_rst   = prst_q;
   assign bus.turn_cnt  = turn_q;
   assign bus.game_over = over_q;
   assign bus.winner    = win_q;
endmodule

// File: tb/tb_duel_referee.sv
// Randomized self-checking bench for duel_referee, driven and sampled on the
// falling clock edge. The reference is a per-turn transaction model: which
// actions reach the step, and how the duel is judged from health and turn count.
module tb_duel_referee;
   localparam int MAXT = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0, n_fail = 0;
   int   m_turns = 0, m_win = 0;
   bit   m_over = 1'b1;

   duel_referee_if bus();

   duel_referee #(.MAX_TURNS(MAXT), .TIMEOUT_CYC(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic finish_now();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   // code the Players should see for an accepted action
   function automatic int eff_code(input int a);
      return (a == 7) ? 0 : a;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy1"},  bus.p1_in_rdy, 0);
      chk({tag, "_rdy2"},  bus.p2_in_rdy, 0);
      chk({tag, "_act1"},  bus.p1_act, 0);
      chk({tag, "_act2"},  bus.p2_act, 0);
      chk({tag, "_en_n"},  bus.ply_en_n, 1);
      chk({tag, "_sw"},    bus.ply_sw, 0);
      chk({tag, "_prst"},  bus.ply_rst, 0);
      chk({tag, "_turn"},  bus.turn_cnt, 0);
      chk({tag, "_over"},  bus.game_over, 0);
      chk({tag, "_win"},   bus.winner, 0);
   endtask

   // Called at a falling edge with the DUT in IDLE or OVER.
   task automatic start_duel();
      bus.start = 1'b1;
      @(negedge clk);
      chk("init_ply_rst", bus.ply_rst, 1);
      chk("init_rdy1", bus.p1_in_rdy, 0);
      bus.start = 1'b0;
      @(negedge clk);
      chk("col_ply_rst", bus.ply_rst, 0);
      chk("col_rdy1", bus.p1_in_rdy, 1);
      chk("col_rdy2", bus.p2_in_rdy, 1);
      chk("col_en_n", bus.ply_en_n, 1);
      chk("col_turn", bus.turn_cnt, 0);
      chk("col_over", bus.game_over, 0);
      chk("col_win", bus.winner, 0);
      m_turns = 0;
      m_over  = 1'b0;
   endtask

   // One turn, entered at the falling edge of the first COLLECT cycle.
   // dX: cycles before player X offers its action; spam keeps vld high after
   // acceptance; rstep asserts rst during the STEP cycle.
   task automatic do_turn(input int a1, input int d1, input int a2, input int d2,
                          input int h1, input int h2, input bit spam, input bit rstep);
      bit dn1 = 1'b0, dn2 = 1'b0, ok = 1'b0, v1, v2;
      int e1, e2;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (dn1) chk("rdy1_full", bus.p1_in_rdy, 0); else chk("rdy1_empty", bus.p1_in_rdy, 1);
         if (dn2) chk("rdy2_full", bus.p2_in_rdy, 0); else chk("rdy2_empty", bus.p2_in_rdy, 1);
         v1 = !dn1 && cyc >= d1;
         v2 = !dn2 && cyc >= d2;
         bus.p1_in_vld = v1 || (dn1 && spam);
         bus.p2_in_vld = v2 || (dn2 && spam);
         bus.p1_in_act = v1 ? 3'(a1) : 3'($urandom);
         bus.p2_in_act = v2 ? 3'(a2) : 3'($urandom);
         bus.start     = ($urandom_range(7) == 0);
         dn1 = dn1 | v1;
         dn2 = dn2 | v2;
         if (dn1 && dn2) begin ok = 1'b1; break; end
`ifdef DUEL_TIMEOUT_EN
         if (cyc == TMO - 1) begin ok = 1'b1; break; end
`endif
         @(negedge clk);
      end
      if (!ok) begin
         chk("collect_bound", 0, 1);
         finish_now();
      end
      e1 = dn1 ? eff_code(a1) : 0;
      e2 = dn2 ? eff_code(a2) : 0;

      @(negedge clk);
      bus.p1_in_vld = 1'b0;
      bus.p2_in_vld = 1'b0;
      bus.start     = 1'b0;
      chk("step_sw", bus.ply_sw, 1);
      chk("step_en_n", bus.ply_en_n, 0);
      chk("step_act1", bus.p1_act, e1);
      chk("step_act2", bus.p2_act, e2);
      bus.p1_hlt = 2'(h1);
      bus.p2_hlt = 2'(h2);
      if (rstep) begin
         rst = 1'b1;
         @(negedge clk);
         chk_reset("rst_in_step");
         rst = 1'b0;
         m_over  = 1'b1;
         m_turns = 0;
         return;
      end

      @(negedge clk);
      chk("settle_sw", bus.ply_sw, 0);
      chk("settle_en_n", bus.ply_en_n, 1);
      chk("settle_act1", bus.p1_act, e1);
      chk("settle_act2", bus.p2_act, e2);
      @(negedge clk);
      chk("check_sw", bus.ply_sw, 0);
      @(negedge clk);

      if (h1 == 0 || h2 == 0) begin
         m_over = 1'b1;
         m_win  = (h1 == 0 && h2 == 0) ? 3 : (h1 == 0) ? 2 : 1;
      end else begin
         if (m_turns < 255) m_turns++;
         if (m_turns == MAXT) begin
            m_over = 1'b1;
            m_win  = (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
         end
      end
      chk("judge_turn", bus.turn_cnt, m_turns);
      chk("judge_over", bus.game_over, int'(m_over));
      chk("judge_win", bus.winner, m_over ? m_win : 0);
      if (!m_over) begin
         chk("next_rdy1", bus.p1_in_rdy, 1);
         chk("next_rdy2", bus.p2_in_rdy, 1);
         chk("next_act1", bus.p1_act, 0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            bus.p1_in_vld = 1'b1;
            bus.p2_in_vld = 1'b1;
            bus.p1_in_act = 3'($urandom);
            bus.p2_in_act = 3'($urandom);
            @(negedge clk);
            chk("over_rdy1", bus.p1_in_rdy, 0);
            chk("over_rdy2", bus.p2_in_rdy, 0);
            chk("over_hold", bus.game_over, 1);
            chk("over_turn", bus.turn_cnt, m_turns);
            chk("over_win", bus.winner, m_win);
         end
         bus.p1_in_vld = 1'b0;
         bus.p2_in_vld = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dmax;
      bus.start = 1'b0;
      bus.p1_in_vld = 1'b0;
      bus.p2_in_vld = 1'b0;
      bus.p1_in_act = 3'd0;
      bus.p2_in_act = 3'd0;
      bus.p1_hlt = 2'd3;
      bus.p2_hlt = 2'd3;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset("idle_no_start");

      // directed turns: staggered accept, simultaneous accept, KO
      start_duel();
      do_turn(5, 0, 2, 4, 3, 3, 1'b0, 1'b0);
      do_turn(4, 0, 4, 0, 3, 2, 1'b1, 1'b0);
      do_turn(7, 1, 6, 0, 2, 0, 1'b0, 1'b0);
      // turn limit at equal health, restarted from OVER
      start_duel();
      repeat (MAXT) do_turn(int'($urandom_range(7)), 0, int'($urandom_range(7)), 1, 3, 3, 1'b0, 1'b0);
      // reset during STEP
      start_duel();
      do_turn(1, 0, 3, 2, 3, 3, 1'b0, 1'b1);
`ifdef DUEL_TIMEOUT_EN
      // only p1 sends; p2 filled with none by the timeout, then rst in STEP
      start_duel();
      do_turn(3, 0, 2, 1000, 3, 3, 1'b0, 1'b1);
      // p2 accepted in the very cycle the timeout expires: accepted code wins
      start_duel();
      do_turn(3, 0, 4, TMO - 1, 3, 3, 1'b0, 1'b0);
      dmax = TMO + 3;
`else
      dmax = 5;
`endif

      for (int g = 0; g < 30; g++) begin
         start_duel();
         while (!m_over) begin
            int h1, h2;
            h1 = ($urandom_range(9) < 7) ? int'($urandom_range(1, 3)) : int'($urandom_range(3));
            h2 = ($urandom_range(9) < 7) ? int'($urandom_range(1, 3)) : int'($urandom_range(3));
            do_turn(int'($urandom_range(7)), int'($urandom_range(dmax)),
                    int'($urandom_range(7)), int'($urandom_range(dmax)),
                    h1, h2, 1'($urandom_range(1)), 1'b0);
         end
      end

      finish_now();
   end
endmodule
